// File: rtl/spu_sm_norm.sv
// Softmax normalization stage.
// Sums the 8-lane exp values of a row, then forms reciprocal = floor(2^24 / sum)
// with a restoring divider. Re-streamed exp values are scaled by that reciprocal
// to give 8-lane uint8 probabilities. The shared sm_state controller sequences
// the three phases.
module spu_sm_norm #(
    parameter int ACC_W  = 20,
    parameter int RECI_W = 16
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic [2:0] sm_state,
    input  logic       din_valid,
    input  logic [7:0] din_q_0,
    input  logic [7:0] din_q_1,
    input  logic [7:0] din_q_2,
    input  logic [7:0] din_q_3,
    input  logic [7:0] din_q_4,
    input  logic [7:0] din_q_5,
    input  logic [7:0] din_q_6,
    input  logic [7:0] din_q_7,
    input  logic [3:0] output_scale_shift,
    output logic       reci_done,
    output logic       dout_valid,
    output logic [7:0] dout_q_0,
    output logic [7:0] dout_q_1,
    output logic [7:0] dout_q_2,
    output logic [7:0] dout_q_3,
    output logic [7:0] dout_q_4,
    output logic [7:0] dout_q_5,
    output logic [7:0] dout_q_6,
    output logic [7:0] dout_q_7
);

    localparam int PROD_W = 8 + RECI_W;
    localparam int QUO_W  = 25;
    localparam logic [QUO_W-1:0] DIVIDEND = QUO_W'(1) << 24;
    localparam logic [4:0] LAST_STEP = 5'(QUO_W - 1);

    typedef enum logic [2:0] {
        SM_IDLE    = 3'b000,
        SM_STAGE_A = 3'b001,
        SM_RECI    = 3'b011,
        SM_STAGE_B = 3'b100,
        SM_MAX     = 3'b101
    } smState_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } divState_e;

    smState_e smState;
    smState_e prevState_q;
    logic     enteringReci;

    logic [7:0] din [8];

    logic [10:0]      laneSum;
    logic [ACC_W:0]   sumWide;
    logic [ACC_W-1:0] sum_q, sum_d;

    divState_e         divState_q, divState_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [QUO_W-1:0]  divd_q, divd_d;
    logic [ACC_W-1:0]  divisor_q, divisor_d;
    logic [ACC_W-1:0]  rem_q, rem_d;
    logic [QUO_W-2:0]  quo_q, quo_d;
    logic [RECI_W-1:0] reci_q, reci_d;
    logic [ACC_W:0]    trial;
    logic              trialGeq;
    logic [QUO_W-1:0]  quoNext;
    logic [ACC_W-1:0]  remNext;

    logic              accept;
    logic [3:0]        shiftClamped;
    logic              v1_q;
    logic [3:0]        s1_q;
    logic [PROD_W-1:0] prod_q [8];
    logic [PROD_W:0]   roundConst;
    logic [7:0]        dout_d [8];
    logic              doutValid_q;
    logic [7:0]        dout_q [8];

    assign smState = smState_e'(sm_state);

    assign din[0] = din_q_0;
    assign din[1] = din_q_1;
    assign din[2] = din_q_2;
    assign din[3] = din_q_3;
    assign din[4] = din_q_4;
    assign din[5] = din_q_5;
    assign din[6] = din_q_6;
    assign din[7] = din_q_7;

    // Remember last cycle's state so RECI entry can be seen as an edge.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) prevState_q <= SM_IDLE;
        else        prevState_q <= smState;
    end

    assign enteringReci = (smState == SM_RECI) && (prevState_q != SM_RECI);

    // Saturating row sum: cleared in IDLE/MAX, grows on valid STAGE_A beats.
    always_comb begin
        laneSum = '0;
        for (int i = 0; i < 8; i++) laneSum = laneSum + 11'(din[i]);
        sumWide = {1'b0, sum_q} + (ACC_W+1)'(laneSum);
        sum_d   = sum_q;
        if (smState == SM_IDLE || smState == SM_MAX) begin
            sum_d = '0;
        end else if (smState == SM_STAGE_A && din_valid) begin
            sum_d = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    // Divider control: load on entry, 25 restoring steps, abort when RECI is left.
    always_comb begin
        trial     = {rem_q, divd_q[QUO_W-1]};
        trialGeq  = trial >= {1'b0, divisor_q};
        quoNext   = {quo_q, trialGeq};
        remNext   = trialGeq ? ACC_W'(trial - {1'b0, divisor_q}) : trial[ACC_W-1:0];

        divState_d = divState_q;
        cnt_d      = cnt_q;
        divd_d     = divd_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        reci_d     = reci_q;

        if (enteringReci) begin
            divState_d = DIV_BUSY;
            cnt_d      = '0;
            divd_d     = DIVIDEND;
            divisor_d  = sum_q;
            rem_d      = '0;
            quo_d      = '0;
        end else if (smState != SM_RECI) begin
            divState_d = DIV_IDLE;
        end else if (divState_q == DIV_BUSY) begin
            divd_d = {divd_q[QUO_W-2:0], 1'b0};
            rem_d  = remNext;
            quo_d  = quoNext[QUO_W-2:0];
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) begin
                reci_d     = (|quoNext[QUO_W-1:RECI_W]) ? '1 : quoNext[RECI_W-1:0];
                divState_d = DIV_DONE;
            end
        end
    end

    // Divider state and datapath registers.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            divState_q <= DIV_IDLE;
            cnt_q      <= '0;
            divd_q     <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            reci_q     <= '0;
        end else begin
            divState_q <= divState_d;
            cnt_q      <= cnt_d;
            divd_q     <= divd_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            reci_q     <= reci_d;
        end
    end

    assign reci_done = (divState_q == DIV_DONE);

    assign accept       = din_valid && (smState == SM_STAGE_B);
    assign shiftClamped = (output_scale_shift > 4'd8) ? 4'd8 : output_scale_shift;

    // Stage 1: multiply each lane by the reciprocal and tag the beat valid.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
            for (int i = 0; i < 8; i++) prod_q[i] <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                s1_q <= shiftClamped;
                for (int i = 0; i < 8; i++) prod_q[i] <= PROD_W'(din[i]) * PROD_W'(reci_q);
            end
        end
    end

    // Round-half-up and shift each product down to the 8-bit output scale.
    always_comb begin
        roundConst = (PROD_W+1)'(1) << (5'd23 - {1'b0, s1_q});
        for (int i = 0; i < 8; i++) begin
            dout_d[i] = 8'(({1'b0, prod_q[i]} + roundConst) >> (5'd24 - {1'b0, s1_q}));
        end
    end

    // Stage 2: register the scaled lanes; they hold while no beat arrives.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            doutValid_q <= 1'b0;
            for (int i = 0; i < 8; i++) dout_q[i] <= '0;
        end else begin
            doutValid_q <= v1_q;
            if (v1_q) begin
                for (int i = 0; i < 8; i++) dout_q[i] <= dout_d[i];
            end
        end
    end

    assign dout_valid = doutValid_q;
    assign dout_q_0   = dout_q[0];
    assign dout_q_1   = dout_q[1];
    assign dout_q_2   = dout_q[2];
    assign dout_q_3   = dout_q[3];
    assign dout_q_4   = dout_q[4];
    assign dout_q_5   = dout_q[5];
    assign dout_q_6   = dout_q[6];
    assign dout_q_7   = dout_q[7];

endmodule

// File: tb/tb_spu_sm_norm.sv
// Directed testbench for spu_sm_norm: sum, reciprocal, normalization, abort and reset.
module tb_spu_sm_norm;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_STAGE_A = 3'b001;
    localparam logic [2:0] ST_RECI    = 3'b011;
    localparam logic [2:0] ST_STAGE_B = 3'b100;

    localparam logic [63:0] ALL32  = {8{8'd32}};
    localparam logic [63:0] ALL255 = {8{8'd255}};
    localparam logic [63:0] MIXED  = 64'hFF_C8_80_64_0A_06_02_00;
    localparam logic [63:0] MIXED_OUT_Q = 64'h40_32_20_19_03_02_01_00;

    logic        core_clk = 1'b0;
    logic        rst_n    = 1'b1;
    logic [2:0]  sm_state = ST_IDLE;
    logic        din_valid = 1'b0;
    logic [63:0] lanes    = '0;
    logic [3:0]  output_scale_shift = 4'd8;
    logic        reci_done;
    logic        dout_valid;
    logic [7:0]  dout_q_0, dout_q_1, dout_q_2, dout_q_3;
    logic [7:0]  dout_q_4, dout_q_5, dout_q_6, dout_q_7;
    logic [63:0] doutPacked;

    int vectors     = 0;
    int miscompares = 0;

    spu_sm_norm #(.ACC_W(20), .RECI_W(16)) dut (
        .core_clk           (core_clk),
        .rst_n              (rst_n),
        .sm_state           (sm_state),
        .din_valid          (din_valid),
        .din_q_0            (lanes[7:0]),
        .din_q_1            (lanes[15:8]),
        .din_q_2            (lanes[23:16]),
        .din_q_3            (lanes[31:24]),
        .din_q_4            (lanes[39:32]),
        .din_q_5            (lanes[47:40]),
        .din_q_6            (lanes[55:48]),
        .din_q_7            (lanes[63:56]),
        .output_scale_shift (output_scale_shift),
        .reci_done          (reci_done),
        .dout_valid         (dout_valid),
        .dout_q_0           (dout_q_0),
        .dout_q_1           (dout_q_1),
        .dout_q_2           (dout_q_2),
        .dout_q_3           (dout_q_3),
        .dout_q_4           (dout_q_4),
        .dout_q_5           (dout_q_5),
        .dout_q_6           (dout_q_6),
        .dout_q_7           (dout_q_7)
    );

    assign doutPacked = {dout_q_7, dout_q_6, dout_q_5, dout_q_4,
                         dout_q_3, dout_q_2, dout_q_1, dout_q_0};

    always #5 core_clk = ~core_clk;

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] st, input logic v,
                                 input logic [63:0] l, input logic [3:0] s);
        sm_state           = st;
        din_valid          = v;
        lanes              = l;
        output_scale_shift = s;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Clear the sum, stream `beats` STAGE_A beats, then run RECI to completion.
    task automatic runRow(input string tag, input int beats, input logic [63:0] l);
        applyStimulus(ST_IDLE, 1'b0, '0, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_A, 1'b0, '0, 4'd8);
        tick(2);
        for (int b = 0; b < beats; b++) begin
            applyStimulus(ST_STAGE_A, 1'b1, l, 4'd8);
            tick(1);
        end
        applyStimulus(ST_RECI, 1'b0, '0, 4'd8);
        tick(25);
        checkOutput({tag, "_done_c25"}, 64'(reci_done), 64'd0);
        tick(1);
        checkOutput({tag, "_done_c26"}, 64'(reci_done), 64'd1);
    endtask

    // One isolated STAGE_B beat, checking the 2-cycle latency and the lanes.
    task automatic runBeat(input string tag, input logic [63:0] l, input logic [3:0] s,
                           input logic [63:0] expected);
        applyStimulus(ST_STAGE_B, 1'b1, l, s);
        tick(1);
        applyStimulus(ST_STAGE_B, 1'b0, '0, s);
        checkOutput({tag, "_valid_lat1"}, 64'(dout_valid), 64'd0);
        tick(1);
        checkOutput({tag, "_valid_lat2"}, 64'(dout_valid), 64'd1);
        checkOutput({tag, "_dout"}, doutPacked, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 64'(dout_valid), 64'd0);
        checkOutput("reset_done", 64'(reci_done), 64'd0);
        checkOutput("reset_dout", doutPacked, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // sum = 256: quotient 65536 saturates to 0xFFFF
        runRow("sum256", 1, ALL32);
        tick(1);
        checkOutput("sum256_done_hold", 64'(reci_done), 64'd1);
        applyStimulus(ST_STAGE_B, 1'b1, ALL32, 4'd8);
        tick(1);
        checkOutput("sum256_done_drop", 64'(reci_done), 64'd0);
        applyStimulus(ST_STAGE_B, 1'b0, '0, 4'd8);
        checkOutput("sum256_valid_lat1", 64'(dout_valid), 64'd0);
        tick(1);
        checkOutput("sum256_valid_lat2", 64'(dout_valid), 64'd1);
        checkOutput("sum256_dout", doutPacked, ALL32);

        // sum = 1024: reciprocal 16384
        runRow("sum1024", 4, ALL32);
        runBeat("r16384_s8", ALL255, 4'd8, {8{8'd64}});
        runBeat("r16384_s4", ALL255, 4'd4, {8{8'd4}});
        runBeat("r16384_s15clamp", ALL255, 4'd15, {8{8'd64}});

        // Back-to-back beats, then output hold
        applyStimulus(ST_STAGE_B, 1'b1, ALL255, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_B, 1'b1, MIXED, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_B, 1'b0, '0, 4'd8);
        checkOutput("b2b_first_valid", 64'(dout_valid), 64'd1);
        checkOutput("b2b_first_dout", doutPacked, {8{8'd64}});
        tick(1);
        checkOutput("b2b_second_valid", 64'(dout_valid), 64'd1);
        checkOutput("b2b_second_dout", doutPacked, MIXED_OUT_Q);
        tick(1);
        checkOutput("hold_valid", 64'(dout_valid), 64'd0);
        checkOutput("hold_dout", doutPacked, MIXED_OUT_Q);

        // Valid input outside STAGE_B never enters the pipeline
        applyStimulus(ST_IDLE, 1'b1, ALL255, 4'd8);
        tick(2);
        applyStimulus(ST_IDLE, 1'b0, '0, 4'd8);
        checkOutput("idle_beat_valid", 64'(dout_valid), 64'd0);
        checkOutput("idle_beat_dout", doutPacked, MIXED_OUT_Q);

        // Empty sum: reciprocal saturates to 0xFFFF
        runRow("sum0", 0, '0);
        runBeat("r65535_s8", ALL255, 4'd8, ALL255);

        // Accumulator saturation at 0xFFFFF: reciprocal 16
        runRow("sumsat", 600, ALL255);
        runBeat("r16_s8", ALL255, 4'd8, 64'd0);

        // Abort: complete reci=16384, then abandon a sum=256 division at cycle 10
        runRow("abort_pre", 4, ALL32);
        applyStimulus(ST_IDLE, 1'b0, '0, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_A, 1'b1, ALL32, 4'd8);
        tick(1);
        applyStimulus(ST_RECI, 1'b0, '0, 4'd8);
        tick(10);
        checkOutput("abort_done_c10", 64'(reci_done), 64'd0);
        applyStimulus(ST_STAGE_B, 1'b0, '0, 4'd8);
        tick(20);
        checkOutput("abort_done_after", 64'(reci_done), 64'd0);
        runBeat("abort_keep_reci", ALL255, 4'd8, {8{8'd64}});

        // Asynchronous reset with two beats in flight
        applyStimulus(ST_STAGE_B, 1'b1, ALL255, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_B, 1'b1, ALL255, 4'd8);
        tick(1);
        applyStimulus(ST_STAGE_B, 1'b1, ALL255, 4'd8);
        checkOutput("prereset_valid", 64'(dout_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(dout_valid), 64'd0);
        checkOutput("midreset_dout", doutPacked, 64'd0);
        checkOutput("midreset_done", 64'(reci_done), 64'd0);
        applyStimulus(ST_STAGE_B, 1'b0, '0, 4'd8);
        tick(1);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            checkOutput("postreset_valid", 64'(dout_valid), 64'd0);
        end
        checkOutput("postreset_dout", doutPacked, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spu_sm_norm.md
Name: spu_sm_norm

Overview:
Softmax normalization stage. It consumes the 8-lane uint8 exp outputs of the softmax exp unit.
- EU_STAGE_A: accumulates the exp values into a running sum.
- RECI: computes the reciprocal of the sum with a sequential restoring divider.
- EU_STAGE_B: multiplies re-streamed exp values by the reciprocal to produce the 8-lane uint8 softmax probabilities.
It sits directly downstream of the exp unit and is driven by the same sm_state controller.

Parameters:
ACC_W, 20, sum accumulator width (unsigned, saturating)
RECI_W, 16, reciprocal width; reciprocal = floor(2^24 / sum), unsigned Q0.16 of 2^8/sum

Ports:
core_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sm_state  in  3  softmax state: IDLE=000, EU_STAGE_A=001, RECI=011, EU_STAGE_B=100, MAX=101
din_valid  in  1  lane data valid this cycle
din_q_0 .. din_q_7  in  8 each  unsigned exp values, scale 2^-8
output_scale_shift  in  4  output scale exponent s: dout = p * 2^s; legal 0..8, values >8 treated as 8
reci_done  out  1  reciprocal ready, level while in RECI
dout_valid  out  1  output lanes valid
dout_q_0 .. dout_q_7  out  8 each  unsigned softmax probabilities

Behaviour:
- Clocking and reset: one clock (core_clk); reset is asynchronous and active-low (rst_n). Reset clears sum, reci, the divider, both pipeline stages, reci_done, dout_valid and all dout_q to 0 immediately, including mid-operation.
- Accumulator (sum, ACC_W bits):
  - Cleared to 0 on any edge where sm_state is IDLE or MAX.
  - In EU_STAGE_A with din_valid=1: sum <= min(sum + sum of the 8 zero-extended lanes, 2^ACC_W-1).
  - Held in all other states.
  - A beat presented on the last EU_STAGE_A cycle counts.
- Divider:
  - Entry is detected as sm_state==RECI with the registered previous state != RECI; that is cycle 0.
  - Cycle 0 edge: load dividend 2^24 and divisor sum.
  - Cycles 1..25: one restoring quotient bit per cycle, MSB first, 25-bit quotient.
  - End of cycle 25: reci <= quotient saturated to 2^RECI_W-1 if any bit above RECI_W-1 is set. This covers sum<=256, including sum=0.
  - reci_done goes high from cycle 26 and stays high while sm_state==RECI; it drops on the first edge after leaving RECI.
- Abort: if sm_state leaves RECI before cycle 25 completes, the divider stops, reci keeps its previous value, and reci_done is never asserted. Re-entering RECI restarts from cycle 0.
- Normalization pipeline (EU_STAGE_B), 2-cycle latency:
  - Stage 1: prod_i = din_q_i * reci, 24 bits, captured when din_valid=1 and sm_state==EU_STAGE_B; a valid tag is captured alongside.
  - Stage 2: dout_q_i = (prod_i + 2^(23-s)) >> (24-s), truncated to 8 bits. The result never exceeds 255 for legal inputs.
  - dout_valid is high exactly 2 cycles after a qualifying input beat. Back-to-back beats give back-to-back outputs.
- In-flight beats complete even if sm_state changes. Inputs in other states do not enter the pipeline.
- When dout_valid=0, dout_q holds its last value.
- reci persists across softmax rows until overwritten by a completed division.

Test Plan:
- Accumulate and divide at the saturation boundary: in EU_STAGE_A, 1 beat with all lanes = 32 (sum=256), then RECI.
  -> reci_done rises 26 cycles after RECI entry.
  -> In EU_STAGE_B with din all 32 and s=8, dout_q = 32 two cycles after the input, with dout_valid high that cycle.
- Exact reciprocal: 4 beats with all lanes = 32 (sum=1024) -> reci=16384.
  -> din 255, s=8 -> dout 64.
  -> din 255, s=4 -> dout 4.
- Empty sum: IDLE, then EU_STAGE_A with no valid beats, then RECI.
  -> reci=0xFFFF, reci_done at cycle 26.
  -> din 255, s=8 -> dout 255.
- Accumulator saturation: 600 beats with all lanes = 255 -> sum = 0xFFFFF (1048575).
  -> reci=16, and din 255, s=8 -> dout 0.
- Abort: leave RECI at cycle 10 after a prior completed reci=16384.
  -> reci_done stays 0 and reci is still 16384 in the following EU_STAGE_B.
- Async reset mid-EU_STAGE_B with two beats in flight.
  -> dout_valid, dout_q and reci_done go to 0 immediately; no outputs appear after reset release.
